// File: rtl/mem_responder_pkg.sv
// Shared sizing defaults and FSM state encoding for the memory responder.
package mem_responder_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_ram64x8.sv
// Byte array with one synchronous write port and one asynchronous read port.
// The array is deliberately never reset so contents survive a reset.
module ram64x8 #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: CPU-side byte RAM that a streaming loader can fill while
// the CPU is held off; CPU writes during a load are dropped and flagged.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ramaddress,
  input  logic [DATA_W-1:0] ramin,
  input  logic              memWr,
  output logic [DATA_W-1:0] ramout,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_last,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_err
);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] len_q;
  logic              ld_ready_q;
  logic              cpu_hold_q;
  logic              ld_done_q;
  logic              ld_err_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Loader owns the write port in LOAD; the CPU only in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ramaddress;
    wr_data = ramin;
    if (state_q == LOAD) begin
      wr_en   = ld_valid & ld_ready_q;
      wr_addr = ptr_q;
      wr_data = ld_data;
    end else if (state_q == IDLE) begin
      wr_en = memWr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      ld_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_start) begin
            state_q    <= LOAD;
            len_q      <= ld_last;
            ptr_q      <= '0;
            ld_err_q   <= 1'b0;
            ld_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        LOAD: begin
          if (memWr) ld_err_q <= 1'b1;
          if (ld_valid && ld_ready_q) begin
            // Leaving at ptr==len_q means the pointer never has to wrap.
            if (ptr_q == len_q) begin
              state_q    <= DONE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (memWr) ld_err_q <= 1'b1;
          state_q    <= IDLE;
          ld_done_q  <= 1'b0;
          cpu_hold_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          ld_done_q  <= 1'b0;
        end
      endcase
    end
  end

  ram64x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(wr_data),
    .raddr_i(ramaddress),
    .rdata_o(ramout)
  );

  assign ld_ready = ld_ready_q;
  assign cpu_hold = cpu_hold_q;
  assign ld_done  = ld_done_q;
  assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: stimulus pushes expected flags/read data per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ramaddress;
  logic [7:0] ramin;
  logic       memWr;
  logic [7:0] ramout;
  logic       ld_start;
  logic [5:0] ld_last;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cpu_hold;
  logic       ld_done;
  logic       ld_err;

  mem_responder #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ramaddress(ramaddress),
    .ramin     (ramin),
    .memWr     (memWr),
    .ramout    (ramout),
    .ld_start  (ld_start),
    .ld_last   (ld_last),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .ld_done   (ld_done),
    .ld_err    (ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         is_flags;
    logic [5:0] addr;
    logic [7:0] exp;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [64];
  bit         exp_err = 1'b0;

  // Monitor: compare everything expected for the current cycle.
  exp_t       mon_e;
  logic [7:0] mon_act;
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.is_flags) mon_act = {4'b0, ld_ready, cpu_hold, ld_done, ld_err};
      else                mon_act = ramout;
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d addr=%0d actual=%h required=%h",
                 mon_e.is_flags ? "flags{rdy,hold,done,err}" : "ramout",
                 mon_e.cyc, mon_e.addr, mon_act, mon_e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_flags(input bit r, input bit h, input bit d);
    exp_t e;
    e.cyc = cyc; e.is_flags = 1'b1; e.addr = '0;
    e.exp = {4'b0, r, h, d, exp_err};
    exp_q.push_back(e);
  endtask

  task automatic push_read();
    exp_t e;
    e.cyc = cyc; e.is_flags = 1'b0; e.addr = ramaddress;
    e.exp = ref_mem[ramaddress];
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] gen_data(input int mode, input int p);
    if (mode == 1) return 8'(p);
    if (mode == 2) return 8'h3C;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    ld_start = 1'b0; ld_valid = 1'($urandom_range(0, 1));
    memWr = 1'b1; ramaddress = a; ramin = d;
    push_flags(0, 0, 0); push_read();
    tick();
    ref_mem[a] = d;
    memWr = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic cpu_read(input logic [5:0] a);
    ld_start = 1'b0; memWr = 1'b0; ramaddress = a;
    push_flags(0, 0, 0); push_read();
    tick();
    $display("read addr=%0d model=%h", a, ref_mem[a]);
  endtask

  // One load transaction; vlen>0 forces the first vlen ld_valid values from vpat.
  task automatic do_load(input logic [5:0] last, input int dmode, input int vlen,
                         input logic [31:0] vpat, input int conflict_pct,
                         input int abort_after);
    int ptr = 0;
    int idx = 0;
    int stalls = 0;
    int accepted = 0;
    bit fin = 1'b0;
    bit v;
    bit w;
    ld_start = 1'b1; ld_last = last; memWr = 1'b0; ld_valid = 1'b0;
    ramaddress = 6'($urandom_range(0, 63));
    push_flags(0, 0, 0); push_read();
    tick();
    exp_err = 1'b0;
    while (!fin) begin
      if (abort_after >= 0 && accepted == abort_after) begin
        ld_valid = 1'b0; memWr = 1'b0; ld_start = 1'b0;
        reset = 1'b1;
        exp_err = 1'b0;
        push_flags(0, 0, 0); push_read();
        tick();
        reset = 1'b0;
        $display("load last=%0d aborted after %0d bytes", last, accepted);
        return;
      end
      if (vlen > 0) v = (idx < vlen) ? vpat[idx] : 1'b1;
      else          v = ($urandom_range(0, 3) != 0) || (stalls >= 4);
      idx++;
      w = ($urandom_range(0, 99) < conflict_pct);
      ld_valid = v; ld_data = gen_data(dmode, ptr);
      memWr = w; ramin = 8'hFF;
      ramaddress = (conflict_pct == 100) ? 6'd0 : 6'($urandom_range(0, 63));
      ld_start = 1'($urandom_range(0, 1));
      push_flags(1, 1, 0); push_read();
      tick();
      if (w) exp_err = 1'b1;
      if (v) begin
        ref_mem[ptr] = ld_data;
        accepted++;
        stalls = 0;
        if (ptr == int'(last)) fin = 1'b1;
        else ptr++;
      end else begin
        stalls++;
      end
    end
    // DONE cycle: ld_start and memWr here must not start a load or write.
    w = 1'($urandom_range(0, 1));
    ld_valid = 1'($urandom_range(0, 1)); ld_start = 1'b1;
    memWr = w; ramin = 8'hFF; ramaddress = 6'($urandom_range(0, 63));
    push_flags(0, 1, 1); push_read();
    tick();
    if (w) exp_err = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; memWr = 1'b0;
    ramaddress = 6'($urandom_range(0, 63));
    push_flags(0, 0, 0); push_read();
    tick();
    $display("load last=%0d bytes=%0d cycles_in_load=%0d err=%0b", last, accepted, idx, exp_err);
  endtask

  initial begin
    reset = 1'b1; ramaddress = '0; ramin = '0; memWr = 1'b0;
    ld_start = 1'b0; ld_last = '0; ld_valid = 1'b0; ld_data = '0;
    tick();
    push_flags(0, 0, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 64; i++) cpu_write(6'(i), 8'($urandom_range(0, 255)));
    cpu_write(6'h05, 8'hA7);
    cpu_read(6'h05);

    // Full load, back to back, data = address.
    do_load(6'd63, 1, 1, 32'h1, 0, -1);
    for (int i = 0; i < 64; i++) cpu_read(6'(i));

    // Stalled load with ld_valid 1,0,0,1,1.
    do_load(6'd2, 0, 5, 32'b11001, 0, -1);
    for (int i = 0; i < 4; i++) cpu_read(6'(i));

    // CPU writes to address 0 during a load: dropped and flagged.
    do_load(6'd5, 0, 0, 32'h0, 100, -1);
    cpu_read(6'd0);
    cpu_write(6'd9, 8'h5A);
    cpu_read(6'd9);

    // Single-byte load, valid at once; also clears the sticky error.
    do_load(6'd0, 2, 1, 32'h1, 0, -1);
    cpu_read(6'd0);

    // Reset after 2 of 4 bytes.
    for (int i = 0; i < 4; i++) cpu_write(6'(i), 8'($urandom_range(0, 255)));
    do_load(6'd3, 0, 0, 32'h0, 0, 2);
    for (int i = 0; i < 4; i++) cpu_read(6'(i));

    for (int n = 0; n < 6; n++) begin
      do_load(6'($urandom_range(0, 15)), 0, 0, 32'h0, 20, -1);
      for (int k = 0; k < 3; k++) begin
        cpu_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        cpu_read(6'($urandom_range(0, 20)));
      end
    end

    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
